// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done handshake and operand/result bus for alu_seq.
//   master : drives start, op, a, b, flag_c_in; observes busy, done, out and flags
//   slave  : the ALU side of the same signals
// Parameters: WIDTH (datapath width), OP_W (opcode width).
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
);
  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flag_c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             flag_c_out;
  logic             flag_z;
  logic             flag_div0;

  modport master (
    output start, op, a, b, flag_c_in,
    input  busy, done, out, flag_c_out, flag_z, flag_div0
  );

  modport slave (
    input  start, op, a, b, flag_c_in,
    output busy, done, out, flag_c_out, flag_z, flag_div0
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with a start/busy/done handshake.
//   Logic, add and subtract ops complete in one cycle. DIV/MOD run an
//   iterative restoring divider producing one quotient bit per edge; MUL
//   (optional) runs a shift-add multiplier with the same timing.
// Ports:
//   clk  - system clock, all state changes on posedge
//   rst  - synchronous active-high reset; aborts any op in flight
//   bus  - alu_seq_if.slave: start/op/a/b/flag_c_in in,
//          busy/done/out/flag_c_out/flag_z/flag_div0 out (all registered)
// Configuration macro:
//   ALU_SEQ_MUL_EN - when defined, opcode 9 is an iterative multiply
//                    (low half in out, flag_c_out = high half nonzero);
//                    when undefined, opcode 9 is treated as illegal and no
//                    multiplier datapath is built.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDC = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUBB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MOD  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(9);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  state_t           state_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] out_reg;
  logic             flag_c_reg;
  logic             flag_z_reg;
  logic             flag_div0_reg;

  // Iteration state. rem_reg/q_reg hold remainder/quotient-shift for the
  // divider and high/low product halves for the multiplier.
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_reg;
  logic             mod_reg;
  logic             c_in_reg;
  logic [CNT_W-1:0] cnt_reg;
`ifdef ALU_SEQ_MUL_EN
  logic             mul_reg;
`endif

  // ---------------------------------------------------------------------
  // Single-cycle result and dispatch decision for the op at the ports.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] sc_out;
  logic             sc_c;
  logic             sc_div0;
  logic             start_iter;

  always_comb begin
    arith      = '0;
    sc_out     = '0;
    sc_c       = bus.flag_c_in;
    sc_div0    = 1'b0;
    start_iter = 1'b0;
    case (bus.op)
      OP_ADD: begin
        arith  = {1'b0, bus.a} + {1'b0, bus.b};
        sc_out = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
      end
      OP_ADDC: begin
        arith  = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.flag_c_in);
        sc_out = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow.
        arith  = {1'b0, bus.a} - {1'b0, bus.b};
        sc_out = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
      end
      OP_SUBB: begin
        arith  = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH+1)'(bus.flag_c_in);
        sc_out = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
      end
      OP_AND: sc_out = bus.a & bus.b;
      OP_OR:  sc_out = bus.a | bus.b;
      OP_XOR: sc_out = bus.a ^ bus.b;
      OP_DIV, OP_MOD: begin
        // Divide by zero is resolved immediately without iterating.
        if (bus.b == '0) begin
          sc_div0 = 1'b1;
          sc_out  = (bus.op == OP_DIV) ? '1 : bus.a;
        end else begin
          start_iter = 1'b1;
        end
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        start_iter = 1'b1;
`else
        sc_out = '0;
`endif
      end
      default: sc_out = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // One iteration step. In IDLE the step is fed from the ports so that the
  // start edge already retires the first bit; in ITER it is fed from the
  // operand registers, leaving the ports free to change.
  // ---------------------------------------------------------------------
  logic             in_idle;
  logic [WIDTH-1:0] rem_src;
  logic [WIDTH-1:0] q_src;
  logic [WIDTH-1:0] d_src;

  assign in_idle = (state_reg == ST_IDLE);
  assign rem_src = in_idle ? '0    : rem_reg;
  assign q_src   = in_idle ? bus.a : q_reg;
  assign d_src   = in_idle ? bus.b : b_reg;

  // Restoring division: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits, and shift the outcome into q.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_q;

  always_comb begin
    div_shift = {rem_src, q_src[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d_src};
    div_ge    = (div_shift >= {1'b0, d_src});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q     = {q_src[WIDTH-2:0], div_ge};
  end

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiply: conditionally add the multiplicand into the high
  // half, then shift the {carry, high, low} chain right by one.
  logic             use_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  assign use_mul = in_idle ? (bus.op == OP_MUL) : mul_reg;

  always_comb begin
    mul_sum = {1'b0, rem_src} + (q_src[0] ? {1'b0, d_src} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], q_src[WIDTH-1:1]};
  end

  assign step_rem = use_mul ? mul_hi : div_rem;
  assign step_q   = use_mul ? mul_lo : div_q;
`else
  assign step_rem = div_rem;
  assign step_q   = div_q;
`endif

  // Result of the final iteration step.
  logic [WIDTH-1:0] fin_out;
  logic             fin_c;

  always_comb begin
    fin_out = mod_reg ? div_rem : div_q;
    fin_c   = c_in_reg;
`ifdef ALU_SEQ_MUL_EN
    if (mul_reg) begin
      fin_out = mul_lo;
      fin_c   = |mul_hi;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs.
  // The start edge computes bit 0 and loads cnt with 1, so cnt names the
  // bit retired on each ITER edge. Bit WIDTH-1 completes the op, giving
  // WIDTH-1 busy cycles and a done pulse WIDTH-1 edges after the start.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_reg       <= '0;
      flag_c_reg    <= 1'b0;
      flag_z_reg    <= 1'b0;
      flag_div0_reg <= 1'b0;
      rem_reg       <= '0;
      q_reg         <= '0;
      b_reg         <= '0;
      mod_reg       <= 1'b0;
      c_in_reg      <= 1'b0;
      cnt_reg       <= '0;
`ifdef ALU_SEQ_MUL_EN
      mul_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (start_iter) begin
              state_reg <= ST_ITER;
              busy_reg  <= 1'b1;
              rem_reg   <= step_rem;
              q_reg     <= step_q;
              b_reg     <= bus.b;
              mod_reg   <= (bus.op == OP_MOD);
              c_in_reg  <= bus.flag_c_in;
              cnt_reg   <= CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
              mul_reg   <= (bus.op == OP_MUL);
`endif
            end else begin
              done_reg      <= 1'b1;
              out_reg       <= sc_out;
              flag_c_reg    <= sc_c;
              flag_z_reg    <= (sc_out == '0);
              flag_div0_reg <= sc_div0;
            end
          end
        end
        ST_ITER: begin
          rem_reg <= step_rem;
          q_reg   <= step_q;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            out_reg       <= fin_out;
            flag_c_reg    <= fin_c;
            flag_z_reg    <= (fin_out == '0);
            flag_div0_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.out        = out_reg;
  assign bus.flag_c_out = flag_c_reg;
  assign bus.flag_z     = flag_z_reg;
  assign bus.flag_div0  = flag_div0_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized + directed self-checking bench for alu_seq.
// Expected results come from an arithmetic reference model and are queued
// when a request is issued; an independent monitor pops and compares on
// every done pulse. The driver also checks latency and busy duration.
module tb_alu_seq;
  localparam int W    = 16;
  localparam int OP_W = 4;

  typedef struct {
    int           op;
    logic [W-1:0] out;
    logic         c;
    logic         z;
    logic         d0;
    logic         iter;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(W), .OP_W(OP_W)) bus ();

  alu_seq #(.WIDTH(W), .OP_W(OP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(int op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
    exp_t   e;
    longint s;
    longint mask;
    mask   = (longint'(1) << W) - 1;
    e.op   = op;
    e.out  = '0;
    e.c    = cin;
    e.d0   = 1'b0;
    e.iter = 1'b0;
    case (op)
      0, 1: begin
        s     = longint'(a) + longint'(b) + ((op == 1) ? longint'(cin) : 0);
        e.out = W'(s & mask);
        e.c   = (s > mask);
      end
      2, 3: begin
        s     = longint'(a) - longint'(b) - ((op == 3) ? longint'(cin) : 0);
        e.out = W'(s & mask);
        e.c   = (s < 0);
      end
      4, 8: begin
        if (b == 0) begin
          e.d0  = 1'b1;
          e.out = (op == 8) ? W'(mask) : a;
        end else begin
          e.iter = 1'b1;
          e.out  = (op == 8) ? W'(longint'(a) / longint'(b)) : W'(longint'(a) % longint'(b));
        end
      end
      5: e.out = a & b;
      6: e.out = a | b;
      7: e.out = a ^ b;
      9: begin
`ifdef ALU_SEQ_MUL_EN
        s      = longint'(a) * longint'(b);
        e.out  = W'(s & mask);
        e.c    = ((s >> W) != 0);
        e.iter = 1'b1;
`else
        e.out = '0;
`endif
      end
      default: e.out = '0;
    endcase
    e.z = (e.out == '0);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got out=0x%0h with no request pending, expected none", bus.out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out !== e.out || bus.flag_c_out !== e.c || bus.flag_z !== e.z || bus.flag_div0 !== e.d0) begin
          errors++;
          $display("FAIL result op=%0d: got out=0x%0h c=%b z=%b div0=%b, expected out=0x%0h c=%b z=%b div0=%b",
                   e.op, bus.out, bus.flag_c_out, bus.flag_z, bus.flag_div0, e.out, e.c, e.z, e.d0);
        end else begin
          $display("txn op=%0d out=0x%0h c=%b z=%b div0=%b ok", e.op, bus.out, bus.flag_c_out, bus.flag_z, bus.flag_div0);
        end
      end
    end
  end

  // Issue one request at a negedge and wait (bounded) for its done.
  // With inject set, a stray ADD start is pulsed while the op is busy.
  task automatic issue(int op, logic [W-1:0] a, logic [W-1:0] b, logic cin, bit inject);
    exp_t e;
    int   lat;
    int   nb;
    e = model(op, a, b, cin);
    sb.push_back(e);
    bus.start     = 1'b1;
    bus.op        = OP_W'(op);
    bus.a         = a;
    bus.b         = b;
    bus.flag_c_in = cin;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.flag_c_in = 1'($urandom);
    lat = 0;
    nb  = 0;
    while (!bus.done && lat < 64) begin
      if (bus.busy) nb++;
      bus.start = (inject && lat == 4);
      if (bus.start) begin
        bus.op = OP_W'(0);
        bus.a  = W'(1);
        bus.b  = W'(1);
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check($sformatf("latency_op%0d", op), 32'(lat), e.iter ? 32'(W - 1) : 32'd0);
    check($sformatf("busy_cycles_op%0d", op), 32'(nb), e.iter ? 32'(W - 1) : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.flag_c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_out", 32'(bus.out), 0);
    check("rst_flags", {29'd0, bus.flag_c_out, bus.flag_z, bus.flag_div0}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(4, 16'd100, 16'd7, 1'b0, 1'b0);
    issue(8, 16'd100, 16'd7, 1'b1, 1'b0);
    issue(8, 16'h1234, 16'h0000, 1'b0, 1'b0);
    issue(4, 16'h1234, 16'h0000, 1'b1, 1'b0);
    issue(8, 16'd1000, 16'd10, 1'b0, 1'b1);
    issue(0, 16'd1, 16'd1, 1'b0, 1'b0);
    issue(9, 16'h0100, 16'h0100, 1'b0, 1'b0);
    issue(8, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(4, 16'h0005, 16'hFFFF, 1'b0, 1'b0);
    issue(12, 16'h55AA, 16'h1234, 1'b1, 1'b0);

    // Reset in the middle of a MOD discards it
    bus.start = 1'b1;
    bus.op    = OP_W'(4);
    bus.a     = 16'd5000;
    bus.b     = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_out", 32'(bus.out), 0);
    check("midrst_div0", 32'(bus.flag_div0), 0);
    issue(2, 16'd3, 16'd5, 1'b0, 1'b0);
    issue(3, 16'd3, 16'd3, 1'b1, 1'b0);

    // Randomized traffic, back-to-back
    for (int i = 0; i < 200; i++) begin
      int           op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = int'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
      issue(op, a, b, 1'($urandom), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
